bulls_cows_engine: RTL

Parametrised game core for the xAyB number-guessing game ("Bulls and Cows"). It generalises the fixed 3-digit scorer to DIGITS positions and adds validity checking, multi-cycle sequential scoring, a try limit with WIN/LOSE states, and a guess-history buffer. It sits between the keypad/number-entry logic and the VGA text renderer, which reads results and history through the ports below.

---
 rtl/bulls_cows_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/bulls_cows_engine.sv
// Bulls-and-Cows game core: validates entries, scores a guess one position per
// cycle, tracks tries toward WIN/LOSE and keeps a circular history of results.
module bulls_cows_engine #(
    parameter int  DIGITS     = 4,
    parameter int  MAX_TRIES  = 10,
    parameter int  HIST_DEPTH = 8,
    localparam int CW         = $clog2(DIGITS + 1),
    localparam int HW         = $clog2(HIST_DEPTH + 1),
    localparam int IW         = $clog2(HIST_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] iNum,
    input  logic                iNumRdy,
    input  logic                iNewGame,
    output logic [2:0]          oState,
    output logic [CW-1:0]       oA,
    output logic [CW-1:0]       oB,
    output logic                oResValid,
    output logic                oErr,
    output logic [7:0]          oTries,
    output logic [HW-1:0]       oHistCnt,
    input  logic [IW-1:0]       iRdIdx,
    output logic [4*DIGITS-1:0] oRdGuess,
    output logic [CW-1:0]       oRdA,
    output logic [CW-1:0]       oRdB
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_SCORE = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] secret_q, guess_q;
    logic [CW-1:0]       pos_q, acc_a_q, acc_b_q, a_q, b_q;
    logic                res_valid_q, err_q;
    logic [7:0]          tries_q;
    logic [IW-1:0]       wptr_q;
    logic [HW-1:0]       hist_cnt_q;
    logic [4*DIGITS-1:0] hist_guess_q [HIST_DEPTH];
    logic [CW-1:0]       hist_a_q     [HIST_DEPTH];
    logic [CW-1:0]       hist_b_q     [HIST_DEPTH];
    logic [4*DIGITS-1:0] rd_guess_q;
    logic [CW-1:0]       rd_a_q, rd_b_q;

    logic                num_valid, hit_a, hit_b, entry_ok, accept, reject, score_done;
    logic [3:0]          cur_g;
    logic [7:0]          tries_inc;
    logic [IW-1:0]       rd_slot;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        num_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (iNum[4*i +: 4] > 4'd9) num_valid = 1'b0;
            for (int k = i + 1; k < DIGITS; k++)
                if (iNum[4*i +: 4] == iNum[4*k +: 4]) num_valid = 1'b0;
        end
    end

    // Bull/cow contribution of the guess digit currently selected by pos_q.
    always_comb begin
        cur_g = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (pos_q == CW'(j)) begin
                cur_g = guess_q[4*j +: 4];
                hit_a = (cur_g == secret_q[4*j +: 4]);
                for (int k = 0; k < DIGITS; k++)
                    if (k != j && cur_g == secret_q[4*k +: 4]) hit_b = 1'b1;
            end
        end
        hit_b = hit_b & ~hit_a;
    end

    assign entry_ok   = (state_q == S_IDLE || state_q == S_PLAY) && iNumRdy && !iNewGame;
    assign accept     = entry_ok && num_valid;
    assign reject     = entry_ok && !num_valid;
    assign score_done = (state_q == S_SCORE) && (pos_q == CW'(DIGITS));
    assign tries_inc  = tries_q + 8'd1;
    assign rd_slot    = wptr_q - IW'(1) - iRdIdx;

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (iNewGame) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_PLAY;
                S_PLAY:  if (accept) state_d = S_SCORE;
                S_SCORE: if (score_done) begin
                    if (acc_a_q == CW'(DIGITS))           state_d = S_WIN;
                    else if (tries_inc == 8'(MAX_TRIES)) state_d = S_LOSE;
                    else                                 state_d = S_PLAY;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        oState    = state_q;
        oA        = a_q;
        oB        = b_q;
        oResValid = res_valid_q;
        oErr      = err_q;
        oTries    = tries_q;
        oHistCnt  = hist_cnt_q;
        oRdGuess  = rd_guess_q;
        oRdA      = rd_a_q;
        oRdB      = rd_b_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            secret_q    <= '0;
            guess_q     <= '0;
            pos_q       <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            tries_q     <= '0;
            wptr_q      <= '0;
            hist_cnt_q  <= '0;
        end else begin
            res_valid_q <= 1'b0;
            err_q       <= reject;
            if (iNewGame) begin
                secret_q   <= '0;
                a_q        <= '0;
                b_q        <= '0;
                tries_q    <= '0;
                wptr_q     <= '0;
                hist_cnt_q <= '0;
            end else begin
                if (accept && state_q == S_IDLE) secret_q <= iNum;
                if (accept && state_q == S_PLAY) begin
                    guess_q <= iNum;
                    pos_q   <= '0;
                    acc_a_q <= '0;
                    acc_b_q <= '0;
                end
                if (state_q == S_SCORE && !score_done) begin
                    pos_q   <= pos_q + CW'(1);
                    acc_a_q <= acc_a_q + CW'(hit_a);
                    acc_b_q <= acc_b_q + CW'(hit_b);
                end
                if (score_done) begin
                    a_q         <= acc_a_q;
                    b_q         <= acc_b_q;
                    res_valid_q <= 1'b1;
                    tries_q     <= tries_inc;
                    wptr_q      <= wptr_q + IW'(1);
                    if (hist_cnt_q != HW'(HIST_DEPTH)) hist_cnt_q <= hist_cnt_q + HW'(1);
                end
            end
        end
    end

    // NOTE: history storage has no reset; slots beyond oHistCnt are masked on read.
    always_ff @(posedge clk) begin
        if (!reset && !iNewGame && score_done) begin
            hist_guess_q[wptr_q] <= guess_q;
            hist_a_q[wptr_q]     <= acc_a_q;
            hist_b_q[wptr_q]     <= acc_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || HW'(iRdIdx) >= hist_cnt_q) begin
            rd_guess_q <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
        end else begin
            rd_guess_q <= hist_guess_q[rd_slot];
            rd_a_q     <= hist_a_q[rd_slot];
            rd_b_q     <= hist_b_q[rd_slot];
        end
    end

endmodule
